// File: rtl/ibex_instr_bus_arbiter.sv
// ibex_instr_bus_arbiter
//
// Shares the single instruction-side OBI port between the core fetch path
// and an auxiliary requester, for example a debug program-buffer loader or a
// cache prefill engine.
//
// Arbitration:
//   - Round-robin between the two requesters.
//   - A request that has been presented but not yet granted is locked to its
//     owner, so the bus address stays stable until the grant arrives.
//   - Each granted transaction pushes its requester ID into a small FIFO.
//     Responses are routed to the requester at the head of that FIFO.
//
// Optional feature (macro IBEX_INSTR_ARB_CNT_EN):
//   - Defined: two saturating 16-bit grant counters are built.
//   - Undefined: both counter outputs are tied to zero.
//
// Parameters:
//   MaxOutstanding  depth of the ID FIFO, 1..4. This is the maximum number of
//                   granted but unanswered transactions.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   core_req_i/addr_i/gnt_o       core request channel
//   core_rvalid_o/rdata_o/err_o   core response channel
//   aux_*                         same, for the auxiliary requester
//   instr_req_o/addr_o/gnt_i      shared bus request channel
//   instr_rvalid_i/rdata_i/err_i  shared bus response channel
//   busy_o                        at least one transaction outstanding
//   core_grant_cnt_o              core grant counter
//   aux_grant_cnt_o               aux grant counter
//
// State   | meaning
// --------+------------------------------------------------------------
// lock_q  | a request was presented without a grant; selection is pinned
// owner_q | requester holding the lock (OwnerCore / OwnerAux)
// rr_q    | last granted requester; the other one wins the next conflict
module ibex_instr_bus_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,

  input  logic        aux_req_i,
  input  logic [31:0] aux_addr_i,
  output logic        aux_gnt_o,
  output logic        aux_rvalid_o,
  output logic [31:0] aux_rdata_o,
  output logic        aux_err_o,

  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,

  output logic        busy_o,
  output logic [15:0] core_grant_cnt_o,
  output logic [15:0] aux_grant_cnt_o
);

  localparam logic [0:0] OwnerCore = 1'b0;
  localparam logic [0:0] OwnerAux  = 1'b1;

  localparam logic [1:0] LastPtr  = 2'(MaxOutstanding - 1);
  localparam logic [2:0] FullCnt  = 3'(MaxOutstanding);

  logic [0:0] owner_q;
  logic [0:0] rr_q;
  logic [0:0] sel;
  logic       lock_q;

  // The ID storage is sized for the largest legal depth. Only the first
  // MaxOutstanding entries are ever addressed.
  logic [3:0] id_q;
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] cnt_q;

  logic       fifo_full, fifo_empty;
  logic       sel_req;
  logic       handshake;
  logic       push, pop;
  logic [0:0] head_id;

  // Requester selection:
  //   - While locked, the owner keeps the bus.
  //   - A conflict goes to the requester that was not granted last.
  //   - When idle, the core is selected, so the core address is forwarded.
  always_comb begin
    sel = OwnerCore;
    if (lock_q) begin
      sel = owner_q;
    end else if (core_req_i && aux_req_i) begin
      sel = ~rr_q;
    end else if (aux_req_i) begin
      sel = OwnerAux;
    end
  end

  assign fifo_full  = (cnt_q == FullCnt);
  assign fifo_empty = (cnt_q == 3'd0);

  assign sel_req      = (sel == OwnerAux) ? aux_req_i : core_req_i;
  assign instr_req_o  = sel_req & ~fifo_full;
  assign instr_addr_o = (sel == OwnerAux) ? aux_addr_i : core_addr_i;

  assign handshake  = instr_req_o & instr_gnt_i;
  assign core_gnt_o = handshake & (sel == OwnerCore);
  assign aux_gnt_o  = handshake & (sel == OwnerAux);

  assign push    = handshake;
  assign pop     = instr_rvalid_i & ~fifo_empty;
  assign head_id = id_q[rd_ptr_q];

  // A response that arrives while the FIFO is empty has no owner, so it is
  // dropped: neither requester sees it.
  assign core_rvalid_o = pop & (head_id == OwnerCore);
  assign aux_rvalid_o  = pop & (head_id == OwnerAux);
  assign core_err_o    = core_rvalid_o & instr_err_i;
  assign aux_err_o     = aux_rvalid_o & instr_err_i;
  assign core_rdata_o  = instr_rdata_i;
  assign aux_rdata_o   = instr_rdata_i;

  assign busy_o = ~fifo_empty;

  // The lock is simply "presented but not granted this cycle".
  // It drops on the handshake. It also drops if the owner withdraws its
  // request, because then instr_req_o is low. It is never set while the FIFO
  // is full, because instr_req_o is low in that state too.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q  <= 1'b0;
      owner_q <= OwnerCore;
      rr_q    <= OwnerAux;
    end else begin
      lock_q <= instr_req_o & ~instr_gnt_i;
      if (instr_req_o && !instr_gnt_i) begin
        owner_q <= sel;
      end
      if (handshake) begin
        rr_q <= sel;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= (wr_ptr_q == LastPtr) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? 2'd0 : rd_ptr_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef IBEX_INSTR_ARB_CNT_EN
  logic [15:0] core_cnt_q, aux_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_cnt_q <= '0;
      aux_cnt_q  <= '0;
    end else begin
      if (core_gnt_o && (core_cnt_q != 16'hFFFF)) begin
        core_cnt_q <= core_cnt_q + 16'd1;
      end
      if (aux_gnt_o && (aux_cnt_q != 16'hFFFF)) begin
        aux_cnt_q <= aux_cnt_q + 16'd1;
      end
    end
  end

  assign core_grant_cnt_o = core_cnt_q;
  assign aux_grant_cnt_o  = aux_cnt_q;
`else
  assign core_grant_cnt_o = 16'h0000;
  assign aux_grant_cnt_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
module tb_ibex_instr_bus_arbiter;

  localparam int unsigned MAXO = 2;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, aux_req, gnt, rvalid, err;
  logic [31:0] core_addr, aux_addr, rdata;
  logic        core_gnt, core_rvalid, core_err, aux_gnt, aux_rvalid, aux_err;
  logic [31:0] core_rdata, aux_rdata, bus_addr;
  logic        bus_req, busy;
  logic [15:0] core_cnt, aux_cnt;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ibex_instr_bus_arbiter #(.MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_addr_i(core_addr), .core_gnt_o(core_gnt),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata), .core_err_o(core_err),
    .aux_req_i(aux_req), .aux_addr_i(aux_addr), .aux_gnt_o(aux_gnt),
    .aux_rvalid_o(aux_rvalid), .aux_rdata_o(aux_rdata), .aux_err_o(aux_err),
    .instr_req_o(bus_req), .instr_addr_o(bus_addr), .instr_gnt_i(gnt),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata), .instr_err_i(err),
    .busy_o(busy), .core_grant_cnt_o(core_cnt), .aux_grant_cnt_o(aux_cnt)
  );

  typedef struct {
    logic creq; logic [31:0] caddr; logic areq; logic [31:0] aaddr;
    logic gnt; logic rv; logic [31:0] rdata; logic err;
    logic e_cg; logic e_ag; logic e_req; logic [31:0] e_addr;
    logic e_crv; logic e_arv; logic e_cerr; logic e_aerr; logic e_busy;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  task automatic cmp(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic [31:0] ca, input logic ar,
                       input logic [31:0] aa, input logic g, input logic r,
                       input logic [31:0] d, input logic e);
    core_req = cr; core_addr = ca; aux_req = ar; aux_addr = aa;
    gnt = g; rvalid = r; rdata = d; err = e;
  endtask

  function automatic logic [79:0] pack_out(
      input logic cg, input logic ag, input logic rq, input logic [31:0] ad,
      input logic crv, input logic arv, input logic ce, input logic ae,
      input logic b, input logic [31:0] d1, input logic [31:0] d2);
    // Only the low bits of the two rdata copies are packed, to fit the width.
    return {cg, ag, rq, ad, crv, arv, ce, ae, b, d1[15:0], d2[15:0]};
  endfunction

  task automatic do_reset();
    drive(L, 32'h0, L, 32'h0, L, L, 32'h0, L);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reference model state for the random phase.
  int m_q[$];
  int m_locked, m_owner, m_last, m_ccnt, m_acnt;
  logic c_pend, a_pend;
  logic [31:0] c_a, a_a;

  initial begin
    rst_n = 1'b1;
    drive(L, 32'h0, L, 32'h0, L, L, 32'h0, L);
    #2 rst_n = 1'b0;
    #1;
    cmp("reset_outputs", pack_out(core_gnt, aux_gnt, bus_req, bus_addr, core_rvalid,
        aux_rvalid, core_err, aux_err, busy, 32'h0, 32'h0),
        pack_out(L, L, L, 32'h0, L, L, L, L, L, 32'h0, 32'h0));
    cmp("reset_counters", {48'h0, core_cnt, aux_cnt}, 80'h0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;

    // Fields: creq caddr areq aaddr gnt rv rdata err | cg ag req addr crv arv cerr aerr busy
    // Conflict right after reset, then interleaved responses.
    v = '{H, 32'h100, H, 32'h200, H, L, 32'h0, L,  H, L, H, 32'h100, L, L, L, L, L}; tbl.push_back(v);
    v = '{L, 32'h0, H, 32'h200, H, L, 32'h0, L,    L, H, H, 32'h200, L, L, L, L, H}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, H, 32'hAAAAAAAA, L, L, L, L, 32'h0, H, L, L, L, H}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, H, 32'hBBBBBBBB, H, L, L, L, 32'h0, L, H, L, H, H}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, L, 32'h0, L,      L, L, L, 32'h0, L, L, L, L, L}; tbl.push_back(v);
    // Core only.
    v = '{H, 32'h80, L, 32'h0, H, L, 32'h0, L,     H, L, H, 32'h80, L, L, L, L, L}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, L, 32'h0, L,      L, L, L, 32'h0, L, L, L, L, H}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, H, 32'h13, L,     L, L, L, 32'h0, H, L, L, L, H}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, L, 32'h0, L,      L, L, L, 32'h0, L, L, L, L, L}; tbl.push_back(v);
    // Lock: aux presented, gnt low for 3 cycles while core raises req.
    v = '{L, 32'h0, H, 32'h300, L, L, 32'h0, L,    L, L, H, 32'h300, L, L, L, L, L}; tbl.push_back(v);
    v = '{H, 32'h400, H, 32'h300, L, L, 32'h0, L,  L, L, H, 32'h300, L, L, L, L, L}; tbl.push_back(v);
    v = '{H, 32'h400, H, 32'h300, L, L, 32'h0, L,  L, L, H, 32'h300, L, L, L, L, L}; tbl.push_back(v);
    v = '{H, 32'h400, H, 32'h300, H, L, 32'h0, L,  L, H, H, 32'h300, L, L, L, L, L}; tbl.push_back(v);
    v = '{H, 32'h400, L, 32'h0, H, L, 32'h0, L,    H, L, H, 32'h400, L, L, L, L, H}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, H, 32'h1, L,      L, L, L, 32'h0, L, H, L, L, H}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, H, 32'h2, L,      L, L, L, 32'h0, H, L, L, L, H}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, L, 32'h0, L,      L, L, L, 32'h0, L, L, L, L, L}; tbl.push_back(v);
    // Stray response with empty FIFO.
    v = '{L, 32'h0, L, 32'h0, L, H, 32'hDEAD, H,   L, L, L, 32'h0, L, L, L, L, L}; tbl.push_back(v);
    // Owner withdraws its request while locked.
    v = '{H, 32'h500, L, 32'h0, L, L, 32'h0, L,    L, L, H, 32'h500, L, L, L, L, L}; tbl.push_back(v);
    v = '{L, 32'h500, H, 32'h600, H, L, 32'h0, L,  L, L, L, 32'h500, L, L, L, L, L}; tbl.push_back(v);
    v = '{L, 32'h0, H, 32'h600, H, L, 32'h0, L,    L, H, H, 32'h600, L, L, L, L, L}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, H, 32'h6, L,      L, L, L, 32'h0, L, H, L, L, H}; tbl.push_back(v);
    v = '{L, 32'h0, L, 32'h0, L, L, 32'h0, L,      L, L, L, 32'h0, L, L, L, L, L}; tbl.push_back(v);
    // Full FIFO, then a pop frees a slot one cycle later.
    v = '{H, 32'h700, L, 32'h0, H, L, 32'h0, L,    H, L, H, 32'h700, L, L, L, L, L}; tbl.push_back(v);
    v = '{H, 32'h700, L, 32'h0, H, L, 32'h0, L,    H, L, H, 32'h700, L, L, L, L, H}; tbl.push_back(v);
    v = '{H, 32'h700, L, 32'h0, H, L, 32'h0, L,    L, L, L, 32'h700, L, L, L, L, H}; tbl.push_back(v);
    v = '{H, 32'h700, L, 32'h0, H, H, 32'h7, L,    L, L, L, 32'h700, H, L, L, L, H}; tbl.push_back(v);
    v = '{H, 32'h700, L, 32'h0, H, L, 32'h0, L,    H, L, H, 32'h700, L, L, L, L, H}; tbl.push_back(v);
    v = '{H, 32'h700, L, 32'h0, L, L, 32'h0, L,    L, L, L, 32'h700, L, L, L, L, H}; tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].creq, tbl[i].caddr, tbl[i].areq, tbl[i].aaddr,
            tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].err);
      @(negedge clk);
      cmp($sformatf("table_vec%0d", i),
          pack_out(core_gnt, aux_gnt, bus_req, bus_addr, core_rvalid, aux_rvalid,
                   core_err, aux_err, busy, core_rdata, aux_rdata),
          pack_out(tbl[i].e_cg, tbl[i].e_ag, tbl[i].e_req, tbl[i].e_addr,
                   tbl[i].e_crv, tbl[i].e_arv, tbl[i].e_cerr, tbl[i].e_aerr,
                   tbl[i].e_busy, tbl[i].rdata, tbl[i].rdata));
      @(posedge clk); #1;
    end

`ifdef IBEX_INSTR_ARB_CNT_EN
    cmp("grant_counters", {48'h0, core_cnt, aux_cnt}, {48'h0, 16'd6, 16'd3});
`else
    cmp("grant_counters_tied", {48'h0, core_cnt, aux_cnt}, 80'h0);
`endif

    // Reset with two transactions outstanding: busy drops at once.
    drive(L, 32'h0, L, 32'h0, L, L, 32'h0, L);
    #1;
    cmp("busy_before_reset", {79'h0, busy}, {79'h0, H});
    rst_n = 1'b0;
    #1;
    cmp("busy_in_reset", {76'h0, busy, bus_req, core_gnt, aux_gnt}, 80'h0);
    cmp("counters_in_reset", {48'h0, core_cnt, aux_cnt}, 80'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    // A late response after reset hits the empty FIFO.
    drive(L, 32'h0, L, 32'h0, L, H, 32'h55, L);
    @(negedge clk);
    cmp("late_rvalid_after_reset", {77'h0, core_rvalid, aux_rvalid, busy}, 80'h0);
    @(posedge clk); #1;

    // Random phase, checked against the queue-based model.
    do_reset();
    m_q.delete();
    m_locked = 0; m_owner = 0; m_last = 1; m_ccnt = 0; m_acnt = 0;
    c_pend = L; a_pend = L; c_a = 32'h0; a_a = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int sel, full, ereq, ecg, eag, ecrv, earv, eb;
      logic [31:0] eaddr;
      if (!c_pend && ($urandom_range(2) == 0)) begin c_pend = H; c_a = $urandom; end
      if (!a_pend && ($urandom_range(2) == 0)) begin a_pend = H; a_a = $urandom; end
      drive(c_pend, c_a, a_pend, a_a, logic'($urandom_range(1)),
            logic'($urandom_range(3) == 0), $urandom, logic'($urandom_range(1)));
      @(negedge clk);
      full = (m_q.size() == MAXO);
      if (m_locked != 0)           sel = m_owner;
      else if (c_pend && a_pend)   sel = 1 - m_last;
      else if (a_pend)             sel = 1;
      else                         sel = 0;
      ereq  = (((sel == 1) ? a_pend : c_pend) && (full == 0)) ? 1 : 0;
      eaddr = (sel == 1) ? a_a : c_a;
      ecg   = (ereq != 0 && gnt && sel == 0) ? 1 : 0;
      eag   = (ereq != 0 && gnt && sel == 1) ? 1 : 0;
      ecrv  = (rvalid && m_q.size() > 0 && m_q[0] == 0) ? 1 : 0;
      earv  = (rvalid && m_q.size() > 0 && m_q[0] == 1) ? 1 : 0;
      eb    = (m_q.size() != 0) ? 1 : 0;
      cmp($sformatf("random_cyc%0d", cyc),
          pack_out(core_gnt, aux_gnt, bus_req, bus_addr, core_rvalid, aux_rvalid,
                   core_err, aux_err, busy, core_rdata, aux_rdata),
          pack_out(logic'(ecg), logic'(eag), logic'(ereq), eaddr, logic'(ecrv),
                   logic'(earv), logic'(ecrv != 0 && err), logic'(earv != 0 && err),
                   logic'(eb), rdata, rdata));
      // Model update.
      if (ecrv != 0 || earv != 0) void'(m_q.pop_front());
      if (ecg != 0 || eag != 0) begin
        m_q.push_back(sel);
        m_last = sel;
        if (ecg != 0) m_ccnt++; else m_acnt++;
      end
      m_locked = (ereq != 0 && !gnt) ? 1 : 0;
      if (m_locked != 0) m_owner = sel;
      if (ecg != 0) c_pend = L;
      if (eag != 0) a_pend = L;
      @(posedge clk); #1;
    end

`ifdef IBEX_INSTR_ARB_CNT_EN
    cmp("random_counters", {48'h0, core_cnt, aux_cnt}, {48'h0, 16'(m_ccnt), 16'(m_acnt)});
`else
    cmp("random_counters_tied", {48'h0, core_cnt, aux_cnt}, 80'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
